// File: rtl/dwrr_pkg.sv
// Constants shared by the DWRR arbiter and its input queues, plus small helpers.
// The per-queue drop counters (macro DWRR_QUEUE_DROP_CNT_EN) use sat_inc8.
package dwrr_pkg;

    localparam int NUM_REQS = 4;   // requestor count
    localparam int QWID     = 8;   // arbiter quantum / deficit width
    localparam int PSIZE    = 1;   // packet cost charged per grant
    localparam int DWID     = 8;   // packet data width
    localparam int DEPTH    = 4;   // default entries per input queue

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/dwrr_fifo.sv
// Single circular FIFO for one requestor queue. A push to a full queue is
// accepted only when the same cycle pops; otherwise it is rejected and flagged.
module dwrr_fifo
#(
    parameter  int DWID   = 8,
    parameter  int DEPTH  = 4,
    localparam int PTRWID = $clog2(DEPTH)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DWID-1:0] push_data,
    input  logic            pop,
    output logic            nonempty,
    output logic            full,
    output logic [DWID-1:0] rd_data,
    output logic            drop
);

    logic [DWID-1:0]   mem_q [DEPTH];
    logic [PTRWID-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRWID-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRWID:0]   count_q, count_d;
    logic              pop_ok_s;
    logic              push_acc_s;

    assign nonempty = (count_q != '0);
    assign full     = (count_q == (PTRWID+1)'(DEPTH));
    assign rd_data  = mem_q[rd_ptr_q];
    assign drop     = push & ~push_acc_s;

    // Next-state pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        pop_ok_s   = pop & nonempty;
        push_acc_s = push & (~full | pop_ok_s);
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTRWID'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTRWID'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        case ({push_acc_s, pop_ok_s})
            2'b10:   count_d = count_q + (PTRWID+1)'(1);
            2'b01:   count_d = count_q - (PTRWID+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_acc_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/dwrr_input_queues.sv
// Per-requestor input queues feeding a DWRR arbiter, with a registered pop output.
// Optional macro DWRR_QUEUE_DROP_CNT_EN adds 8-bit saturating per-queue drop counters.
module dwrr_input_queues
#(
    parameter  int NUM_REQS = dwrr_pkg::NUM_REQS,
    parameter  int DWID     = dwrr_pkg::DWID,
    parameter  int DEPTH    = dwrr_pkg::DEPTH,
    localparam int PTRWID   = $clog2(DEPTH),
    localparam int CNTWID   = $clog2(NUM_REQS)
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQS-1:0]      push,
    input  logic [NUM_REQS*DWID-1:0] push_data,
    input  logic [NUM_REQS-1:0]      gnt,
    output logic [NUM_REQS-1:0]      reqs,
    output logic [NUM_REQS-1:0]      full,
    output logic                     out_valid,
    output logic [DWID-1:0]          out_data,
    output logic [CNTWID-1:0]        out_id
`ifdef DWRR_QUEUE_DROP_CNT_EN
    ,
    output logic [NUM_REQS*8-1:0]    drop_cnt
`endif
);

    import dwrr_pkg::*;

    logic [DWID-1:0]     rd_data_s [NUM_REQS];
    logic [NUM_REQS-1:0] pop_s;
    logic [NUM_REQS-1:0] drop_s;
    logic                found_s;
    logic [CNTWID-1:0]   sel_id_s;
    logic                out_valid_q, out_valid_d;
    logic [DWID-1:0]     out_data_q, out_data_d;
    logic [CNTWID-1:0]   out_id_q, out_id_d;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_q
        dwrr_fifo #(
            .DWID  (DWID),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (push_data[g*DWID +: DWID]),
            .pop       (pop_s[g]),
            .nonempty  (reqs[g]),
            .full      (full[g]),
            .rd_data   (rd_data_s[g]),
            .drop      (drop_s[g])
        );
    end

    // Only the lowest-index grant that hits a non-empty queue pops.
    always_comb begin
        pop_s    = '0;
        found_s  = 1'b0;
        sel_id_s = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!found_s && gnt[i] && reqs[i]) begin
                pop_s[i] = 1'b1;
                sel_id_s = CNTWID'(i);
                found_s  = 1'b1;
            end else begin
                pop_s[i] = 1'b0;
            end
        end
    end

    // Output next-state: data and id hold when nothing pops.
    always_comb begin
        out_valid_d = found_s;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (found_s) begin
            out_data_d = rd_data_s[sel_id_s];
            out_id_d   = sel_id_s;
        end else begin
            out_data_d = out_data_q;
            out_id_d   = out_id_q;
        end
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef DWRR_QUEUE_DROP_CNT_EN
    logic [7:0] drop_cnt_q [NUM_REQS];
    logic [7:0] drop_cnt_d [NUM_REQS];

    // Saturating per-queue count of rejected pushes.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (drop_s[i]) begin
                drop_cnt_d[i] = sat_inc8(drop_cnt_q[i]);
            end else begin
                drop_cnt_d[i] = drop_cnt_q[i];
            end
        end
    end

    // Drop counter registers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rst) begin
                drop_cnt_q[i] <= 8'd0;
            end else begin
                drop_cnt_q[i] <= drop_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_drop
        assign drop_cnt[g*8 +: 8] = drop_cnt_q[g];
    end
`else
    logic unused_drop_s;
    assign unused_drop_s = ^drop_s;
`endif

endmodule

// File: tb/tb_dwrr_input_queues.sv
// Directed self-checking bench for dwrr_input_queues (default parameters).
module tb_dwrr_input_queues;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  push;
    logic [31:0] push_data;
    logic [3:0]  gnt;
    logic [3:0]  reqs;
    logic [3:0]  full;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
`ifdef DWRR_QUEUE_DROP_CNT_EN
    logic [31:0] drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    dwrr_input_queues dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .gnt       (gnt),
        .reqs      (reqs),
        .full      (full),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id)
`ifdef DWRR_QUEUE_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push      = 4'b0000;
        push_data = 32'h0;
        gnt       = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({reqs, full, out_valid, out_data, out_id} !== {4'b0, 4'b0, 1'b0, 8'h00, 2'd0}) begin
            failures++;
            $display("FAIL reset_state: got reqs=%b full=%b ov=%b od=%h id=%0d, want all zero",
                     reqs, full, out_valid, out_data, out_id);
        end
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            push         = 4'b0001;
            push_data    = 32'h0;
            push_data[7:0] = vals[k];
            step();
        end
        checks++;
        if (reqs !== 4'b0001 || full !== 4'b0001) begin
            failures++;
            $display("FAIL fill_full: got reqs=%b full=%b, want 0001/0001", reqs, full);
        end
        push_data[7:0] = 8'h55;
        step();
        idle();
        checks++;
        if (full !== 4'b0001 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_drop: got full=%b ov=%b, want 0001/0", full, out_valid);
        end
`ifdef DWRR_QUEUE_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 32'h0000_0001) begin
            failures++;
            $display("FAIL drop_cnt: got %h want 00000001", drop_cnt);
        end
`endif
    endtask

    task automatic test_drain();
        logic [7:0] exp [4];
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            gnt = 4'b0001;
            step();
            checks++;
            if ({out_valid, out_data, out_id} !== {1'b1, exp[k], 2'd0}) begin
                failures++;
                $display("FAIL drain_%0d: got ov=%b od=%h id=%0d, want 1/%h/0",
                         k, out_valid, out_data, out_id, exp[k]);
            end
        end
        gnt = 4'b0000;
        step();
        checks++;
        if (reqs !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h44) begin
            failures++;
            $display("FAIL drain_end: got reqs=%b ov=%b od=%h, want 0000/0/44", reqs, out_valid, out_data);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        exp = '{8'h02, 8'h03, 8'h04, 8'hAA};
        for (int k = 1; k <= 4; k++) begin
            push      = 4'b0010;
            push_data = 32'h0;
            push_data[15:8] = 8'(k);
            step();
        end
        push_data[15:8] = 8'hAA;
        gnt = 4'b0010;
        step();
        idle();
        checks++;
        if (full !== 4'b0010 || {out_valid, out_data, out_id} !== {1'b1, 8'h01, 2'd1}) begin
            failures++;
            $display("FAIL full_push_pop: got full=%b ov=%b od=%h id=%0d, want 0010/1/01/1",
                     full, out_valid, out_data, out_id);
        end
        for (int k = 0; k < 4; k++) begin
            gnt = 4'b0010;
            step();
            checks++;
            if ({out_valid, out_data, out_id} !== {1'b1, exp[k], 2'd1}) begin
                failures++;
                $display("FAIL full_drain_%0d: got ov=%b od=%h id=%0d, want 1/%h/1",
                         k, out_valid, out_data, out_id, exp[k]);
            end
        end
        idle();
        checks++;
        if (reqs !== 4'b0000) begin
            failures++;
            $display("FAIL full_drain_empty: got reqs=%b want 0000", reqs);
        end
    endtask

    task automatic test_empty_grant();
        gnt = 4'b0100;
        step();
        idle();
        checks++;
        if (out_valid !== 1'b0 || reqs !== 4'b0000) begin
            failures++;
            $display("FAIL empty_grant: got ov=%b reqs=%b, want 0/0000", out_valid, reqs);
        end
        push = 4'b0100;
        push_data[23:16] = 8'h5A;
        step();
        idle();
        gnt = 4'b0100;
        step();
        idle();
        checks++;
        if ({out_valid, out_data, out_id, reqs} !== {1'b1, 8'h5A, 2'd2, 4'b0000}) begin
            failures++;
            $display("FAIL empty_grant_ptr: got ov=%b od=%h id=%0d reqs=%b, want 1/5a/2/0000",
                     out_valid, out_data, out_id, reqs);
        end
    endtask

    task automatic test_multi_grant();
        push      = 4'b1010;
        push_data = {8'h63, 8'h00, 8'h61, 8'h00};
        step();
        idle();
        gnt = 4'b1010;
        step();
        checks++;
        if ({out_valid, out_data, out_id, reqs} !== {1'b1, 8'h61, 2'd1, 4'b1000}) begin
            failures++;
            $display("FAIL multi_grant: got ov=%b od=%h id=%0d reqs=%b, want 1/61/1/1000",
                     out_valid, out_data, out_id, reqs);
        end
        gnt = 4'b1000;
        step();
        idle();
        checks++;
        if ({out_valid, out_data, out_id, reqs} !== {1'b1, 8'h63, 2'd3, 4'b0000}) begin
            failures++;
            $display("FAIL multi_grant_q3: got ov=%b od=%h id=%0d reqs=%b, want 1/63/3/0000",
                     out_valid, out_data, out_id, reqs);
        end
    endtask

    task automatic test_back_to_back();
        push = 4'b0001;
        push_data = 32'h0000_003C;
        gnt  = 4'b0001;
        step();
        idle();
        checks++;
        if (out_valid !== 1'b0 || reqs !== 4'b0001) begin
            failures++;
            $display("FAIL empty_push_pop: got ov=%b reqs=%b, want 0/0001", out_valid, reqs);
        end
        gnt = 4'b0001;
        step();
        idle();
        checks++;
        if ({out_valid, out_data, out_id} !== {1'b1, 8'h3C, 2'd0}) begin
            failures++;
            $display("FAIL empty_push_pop_data: got ov=%b od=%h id=%0d, want 1/3c/0",
                     out_valid, out_data, out_id);
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 3; k++) begin
            push = 4'b1000;
            push_data = 32'h0;
            push_data[31:24] = 8'h71 + 8'(k);
            step();
        end
        idle();
        checks++;
        if (reqs !== 4'b1000) begin
            failures++;
            $display("FAIL mid_fill: got reqs=%b want 1000", reqs);
        end
        rst  = 1'b1;
        push = 4'b1000;
        push_data[31:24] = 8'h7F;
        gnt  = 4'b1000;
        step();
        rst = 1'b0;
        idle();
        checks++;
        if ({reqs, full, out_valid, out_data, out_id} !== {4'b0, 4'b0, 1'b0, 8'h00, 2'd0}) begin
            failures++;
            $display("FAIL mid_reset: got reqs=%b full=%b ov=%b od=%h id=%0d, want all zero",
                     reqs, full, out_valid, out_data, out_id);
        end
`ifdef DWRR_QUEUE_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_drop: got %h want 0", drop_cnt);
        end
`endif
        push = 4'b1000;
        push_data[31:24] = 8'h81;
        step();
        idle();
        gnt = 4'b1000;
        step();
        idle();
        checks++;
        if ({out_valid, out_data, out_id, reqs} !== {1'b1, 8'h81, 2'd3, 4'b0000}) begin
            failures++;
            $display("FAIL post_reset_push: got ov=%b od=%h id=%0d reqs=%b, want 1/81/3/0000",
                     out_valid, out_data, out_id, reqs);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_full_push_pop();
        test_empty_grant();
        test_multi_grant();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwrr_input_queues.md
DWRR_INPUT_QUEUES -- requirements
Module: dwrr_input_queues

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of requestor queues.
REQ-002 SHALL have parameter DWID, default 8: packet data width.
REQ-003 SHALL have parameter DEPTH, default 4: entries per queue; power of two, at least 2.
REQ-004 SHALL have parameters PTRWID = $clog2(DEPTH) and CNTWID = $clog2(NUM_REQS), both derived and never overridden.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 push  input  NUM_REQS  per-queue write strobe.
REQ-009 push_data  input  NUM_REQS*DWID  per-queue write data; queue i uses bits [(i+1)*DWID-1:i*DWID].
REQ-010 gnt  input  NUM_REQS  grant vector from the DWRR arbiter; each asserted bit pops one entry.
REQ-011 reqs  output  NUM_REQS  queue non-empty flags; drive the arbiter's reqs input.
REQ-012 full  output  NUM_REQS  queue full flags, for upstream backpressure.
REQ-013 out_valid  output  1  one popped packet is present on out_data this cycle.
REQ-014 out_data  output  DWID  popped packet data.
REQ-015 out_id  output  CNTWID  index of the queue that out_data came from.

Function
REQ-016 Each queue SHALL be a circular FIFO.
  - Read pointer and write pointer, PTRWID bits each.
  - Occupancy count, PTRWID+1 bits.
  - reqs[i] = (count != 0) and full[i] = (count == DEPTH), both combinational from registered count.
REQ-017 A push to queue i SHALL be accepted when push[i] & (~full[i] | pop[i]); a push to a full queue with no same-cycle pop is dropped, and the queue state does not change.
REQ-018 pop[i] SHALL be gnt[i] & reqs[i]; gnt[i] on an empty queue SHALL be ignored.
REQ-019 When more than one gnt bit is set, only the lowest-index valid pop SHALL occur; the other grants are ignored.
REQ-020 Push and pop on the same queue in the same cycle SHALL leave count unchanged and advance both pointers.
  - On an empty queue, the push is accepted and the gnt is ignored.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-022 Output timing SHALL be as follows:
  - out_valid, out_data and out_id are registered.
  - A pop in cycle t presents its data, the queue index and out_valid=1 in cycle t+1.
  - out_valid is 0 in any cycle following a cycle with no pop.
  - out_data and out_id hold their last values when out_valid=0.
REQ-023 Data SHALL leave each queue in FIFO order, with no loss or duplication for accepted pushes.

Reset
REQ-024 While rst is high at a clock edge, every pointer and count SHALL be cleared, along with out_valid, out_data and out_id (all cleared to 0).
REQ-025 Reset mid-operation SHALL discard all queued entries.
  - The first cycle after reset shows reqs=0, full=0, out_valid=0.
  - push and gnt in the reset cycle are ignored.
REQ-026 Memory contents SHALL not need reset.

Configuration
REQ-027 Macro DWRR_QUEUE_DROP_CNT_EN controls per-queue drop counting.
  - Defined: each queue has an 8-bit saturating drop counter, incremented once per rejected push (REQ-017), reset to 0, and exposed on output drop_cnt (NUM_REQS*8 bits).
  - Undefined: the counters and the port do not exist.

Structure
REQ-028 Shared package dwrr_pkg SHALL hold the default constants shared with the arbiter: NUM_REQS, QWID, PSIZE, DWID.
REQ-029 One sub-module, dwrr_fifo, SHALL implement a single queue (REQ-016 to REQ-021) and be instantiated NUM_REQS times by generate.
  - The pop priority select and the output register stay in the top level.

Verification
REQ-030 Fill: push queue 0 with 0x11,0x22,0x33,0x44 on consecutive cycles -> full[0]=1 and reqs[0]=1; a fifth push of 0x55 is dropped (drop_cnt[0]=1 if enabled).
REQ-031 Drain: gnt=4'b0001 for 4 cycles -> out_data 0x11,0x22,0x33,0x44 on the following cycles with out_id=0, then reqs[0]=0.
REQ-032 Full with simultaneous push and pop: queue 1 full, push 0xAA with gnt[1] -> count stays 4; after draining, 0xAA appears last.
REQ-033 Empty grant: gnt=4'b0100 with queue 2 empty -> out_valid=0 next cycle, no pointer change.
REQ-034 Multi-grant: queues 1 and 3 non-empty, gnt=4'b1010 -> only queue 1 pops; out_id=1.
REQ-035 Reset mid-stream: 3 entries in queue 3, assert rst for one cycle -> next cycle reqs=0, out_valid=0, and later pushes start from empty.
